// File: rtl/cpu_pkg.sv
// cpu_pkg: shared field offsets, control-bit indices and MEM-stage state type.
// Offsets are the LSB of each field inside the EX/MEM (173-bit) and MEM/WB
// (103-bit) bundles; widths are implied by the field (2/5/32/1/5 bits).
package cpu_pkg;
    localparam int EX_MEM_W = 173;
    localparam int MEM_WB_W = 103;
    localparam int EXM_WB   = 171;
    localparam int EXM_MC   = 166;
    localparam int EXM_PC4  = 134;
    localparam int EXM_RD1  = 102;
    localparam int EXM_TGT  = 70;
    localparam int EXM_BRC  = 69;
    localparam int EXM_ALU  = 37;
    localparam int EXM_RD2  = 5;
    localparam int EXM_RD   = 0;
    localparam int MWB_WB   = 101;
    localparam int MWB_PC4  = 69;
    localparam int MWB_MD   = 37;
    localparam int MWB_ALU  = 5;
    localparam int MWB_RD   = 0;
    localparam int MC_MEMREAD  = 0;
    localparam int MC_MEMWRITE = 1;
    localparam int MC_BRANCH   = 2;
    localparam int MC_JUMPREG  = 3;
    localparam int MC_BYTE     = 4;
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} mem_state_t;
endpackage

// File: rtl/mem_access_stage_if.sv
// mem_access_stage_if: req/ack data-memory bus.
// master (stage) drives req/we/addr/wdata/be; slave (memory) drives ack/rdata.
// ack is a one-cycle completion pulse; rdata is valid while ack is high.
interface mem_access_stage_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        ack;
    logic [31:0] rdata;
    modport master(output req, we, addr, wdata, be, input ack, rdata);
    modport slave(input req, we, addr, wdata, be, output ack, rdata);
endinterface

// File: rtl/mem_wb_reg.sv
// mem_wb_reg: MEM/WB pipeline register with bubble insertion.
// Ports: CLK, RSTN (sync active-low), bubble (load all zeros), d -> q.
module mem_wb_reg
    import cpu_pkg::*;
(
    input  logic                CLK,
    input  logic                RSTN,
    input  logic                bubble,
    input  logic [MEM_WB_W-1:0] d,
    output logic [MEM_WB_W-1:0] q
);
    always_ff @(posedge CLK)
        q <= (!RSTN || bubble) ? '0 : d;
endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: pipeline MEM stage - redirect resolution, data-memory
// req/ack access with upstream stall, and the MEM/WB register.
// Ports: CLK, RSTN (sync active-low), EX_MEM_out (173-bit EX/MEM bundle),
// dmem (memory bus, master side, registered outputs), Mem_stall / PCSrc /
// PC_target (combinational), MEM_WB_out (103-bit MEM/WB bundle).
module mem_access_stage
    import cpu_pkg::*;
#(
    parameter int ADDR_LSB = 2
) (
    input  logic                CLK,
    input  logic                RSTN,
    input  logic [EX_MEM_W-1:0] EX_MEM_out,
    mem_access_stage_if.master  dmem,
    output logic                Mem_stall,
    output logic                PCSrc,
    output logic [31:0]         PC_target,
    output logic [MEM_WB_W-1:0] MEM_WB_out
);
    mem_state_t state, state_n;
    logic [1:0]          wb;
    logic [4:0]          mc, rd;
    logic [31:0]         pc4, rd1, tgt, alu, rd2, hold, rdata_sel;
    logic                brc, mem_op, is_load, byte_acc;
    logic [ADDR_LSB-1:0] lane;
    logic [7:0]          lane_byte;

    assign wb       = EX_MEM_out[EXM_WB +: 2];
    assign mc       = EX_MEM_out[EXM_MC +: 5];
    assign pc4      = EX_MEM_out[EXM_PC4 +: 32];
    assign rd1      = EX_MEM_out[EXM_RD1 +: 32];
    assign tgt      = EX_MEM_out[EXM_TGT +: 32];
    assign brc      = EX_MEM_out[EXM_BRC];
    assign alu      = EX_MEM_out[EXM_ALU +: 32];
    assign rd2      = EX_MEM_out[EXM_RD2 +: 32];
    assign rd       = EX_MEM_out[EXM_RD +: 5];
    assign mem_op   = mc[MC_MEMREAD] | mc[MC_MEMWRITE];
    // both bits set means store, so only a pure read returns data
    assign is_load  = mc[MC_MEMREAD] & ~mc[MC_MEMWRITE];
    assign byte_acc = mc[MC_BYTE];
    assign lane     = alu[ADDR_LSB-1:0];

    assign PCSrc     = (mc[MC_BRANCH] & brc) | mc[MC_JUMPREG];
    assign PC_target = mc[MC_JUMPREG] ? rd1 : tgt;

    // EX/MEM is frozen during the access, so ALUresult still selects the lane
    assign lane_byte = 8'(dmem.rdata >> {lane, 3'b000});
    assign rdata_sel = byte_acc ? {24'd0, lane_byte} : dmem.rdata;

    always_ff @(posedge CLK)
        state <= !RSTN ? IDLE : state_n;

    always_comb begin
        state_n = (state == IDLE && mem_op)     ? ACCESS :
                  (state == ACCESS && dmem.ack) ? DONE   :
                  (state == DONE)               ? IDLE   : state;
    end

    always_comb begin
        Mem_stall = (state == IDLE && mem_op) || state == ACCESS;
    end

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            dmem.req   <= 1'b0;
            dmem.we    <= 1'b0;
            dmem.addr  <= '0;
            dmem.wdata <= '0;
            dmem.be    <= '0;
            hold       <= '0;
        end else if (state == IDLE && mem_op) begin
            dmem.req   <= 1'b1;
            dmem.we    <= mc[MC_MEMWRITE];
            dmem.addr  <= {alu[31:ADDR_LSB], {ADDR_LSB{1'b0}}};
            dmem.wdata <= byte_acc ? {4{rd2[7:0]}} : rd2;
            dmem.be    <= byte_acc ? 4'b0001 << lane : 4'hF;
        end else if (state == ACCESS && dmem.ack) begin
            dmem.req   <= 1'b0;
            hold       <= rdata_sel;
        end
    end

    mem_wb_reg u_mem_wb (
        .CLK   (CLK),
        .RSTN  (RSTN),
        .bubble(Mem_stall),
        .d     ({wb, pc4, is_load ? hold : 32'd0, alu, rd}),
        .q     (MEM_WB_out)
    );
endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: scoreboard bench for mem_access_stage.
module tb_mem_access_stage;
    import cpu_pkg::*;
    logic         CLK = 1'b0;
    logic         RSTN = 1'b0;
    logic [172:0] EX_MEM_out = '0;
    logic         Mem_stall, PCSrc;
    logic [31:0]  PC_target;
    logic [102:0] MEM_WB_out;
    int           total = 0, bad = 0, cyc = 0;
    logic [102:0] exp_q[$];
    logic [102:0] mon_e;

    mem_access_stage_if dmem();

    mem_access_stage dut (
        .CLK       (CLK),
        .RSTN      (RSTN),
        .EX_MEM_out(EX_MEM_out),
        .dmem      (dmem),
        .Mem_stall (Mem_stall),
        .PCSrc     (PCSrc),
        .PC_target (PC_target),
        .MEM_WB_out(MEM_WB_out)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc++;

    function automatic logic [172:0] mk(input logic [1:0] wb, input logic [4:0] mc,
        input logic [31:0] pc4, rd1, tgt, input logic brc, input logic [31:0] alu, rd2,
        input logic [4:0] rd);
        return {wb, mc, pc4, rd1, tgt, brc, alu, rd2, rd};
    endfunction

    function automatic logic [102:0] mwb(input logic [1:0] wb, input logic [31:0] pc4, md,
        alu, input logic [4:0] rd);
        return {wb, pc4, md, alu, rd};
    endfunction

    // every non-bubble retirement must match the oldest expected entry
    always @(negedge CLK) begin
        if (RSTN && MEM_WB_out !== '0) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL mwb_unexpected got=%h want=none", MEM_WB_out);
            end else begin
                mon_e = exp_q.pop_front();
                if (MEM_WB_out !== mon_e) begin
                    bad++;
                    $display("FAIL mwb_scoreboard got=%h want=%h", MEM_WB_out, mon_e);
                end
            end
        end
    end

    // Called right after a negedge with the op presented in cycle N; returns
    // at the negedge starting cycle N+k+2 with the op removed.
    task automatic mem_op(input logic [172:0] b, input logic [102:0] e, input int k,
        input logic [31:0] rdata, output int stalls, output logic [31:0] addr,
        output logic [3:0] be, output logic [31:0] wdata, output logic we,
        output logic [102:0] wb_done);
        EX_MEM_out = b;
        exp_q.push_back(e);
        stalls = 0;
        for (int c = 0; c <= k + 1; c++) begin
            dmem.ack = (c == k);
            dmem.rdata = (c == k) ? rdata : 32'h0;
            #1;
            stalls += int'(Mem_stall);
            if (c == 1) begin
                addr = dmem.addr;
                be = dmem.be;
                wdata = dmem.wdata;
                we = dmem.we;
            end
            if (c == k + 1) wb_done = MEM_WB_out;
            @(negedge CLK);
        end
        dmem.ack = 1'b0;
        EX_MEM_out = '0;
    endtask

    task automatic test_reset;
        RSTN = 1'b0;
        repeat (2) @(negedge CLK);
        total++;
        if (dmem.req !== 1'b0) begin bad++; $display("FAIL reset_req got=%b want=0", dmem.req); end
        total++;
        if (MEM_WB_out !== '0) begin bad++; $display("FAIL reset_mwb got=%h want=0", MEM_WB_out); end
        total++;
        if ({dmem.be, dmem.addr} !== '0) begin bad++; $display("FAIL reset_bus got=%h want=0", {dmem.be, dmem.addr}); end
        total++;
        if (Mem_stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b want=0", Mem_stall); end
        RSTN = 1'b1;
        @(negedge CLK);
    endtask

    task automatic test_alu;
        logic [102:0] e;
        e = mwb(2'b10, 32'h104, 32'h0, 32'h55, 5'd3);
        EX_MEM_out = mk(2'b10, 5'b0, 32'h104, 32'h0, 32'h0, 1'b0, 32'h55, 32'h7, 5'd3);
        exp_q.push_back(e);
        #1;
        total++;
        if (Mem_stall !== 1'b0) begin bad++; $display("FAIL alu_stall got=%b want=0", Mem_stall); end
        @(negedge CLK);
        total++;
        if (MEM_WB_out !== e) begin bad++; $display("FAIL alu_latency got=%h want=%h", MEM_WB_out, e); end
        EX_MEM_out = '0;
        @(negedge CLK);
    endtask

    task automatic test_branch;
        EX_MEM_out = mk(2'b00, 5'b00100, 32'h200, 32'h9999, 32'h400, 1'b1, 32'h0, 32'h0, 5'd0);
        exp_q.push_back(mwb(2'b00, 32'h200, 32'h0, 32'h0, 5'd0));
        #1;
        total++;
        if ({PCSrc, PC_target, Mem_stall} !== {1'b1, 32'h400, 1'b0})
            begin bad++; $display("FAIL branch_taken got=%b/%h/%b want=1/400/0", PCSrc, PC_target, Mem_stall); end
        @(negedge CLK);
        EX_MEM_out = mk(2'b00, 5'b00100, 32'h204, 32'h9999, 32'h400, 1'b0, 32'h0, 32'h0, 5'd0);
        exp_q.push_back(mwb(2'b00, 32'h204, 32'h0, 32'h0, 5'd0));
        #1;
        total++;
        if (PCSrc !== 1'b0) begin bad++; $display("FAIL branch_not_taken got=%b want=0", PCSrc); end
        @(negedge CLK);
        EX_MEM_out = '0;
        @(negedge CLK);
    endtask

    task automatic test_jumpreg;
        for (int b = 0; b < 2; b++) begin
            EX_MEM_out = mk(2'b00, 5'b01000, 32'h300 + 32'(b), 32'h8000, 32'h400, b[0], 32'h0, 32'h0, 5'd0);
            exp_q.push_back(mwb(2'b00, 32'h300 + 32'(b), 32'h0, 32'h0, 5'd0));
            #1;
            total++;
            if ({PCSrc, PC_target} !== {1'b1, 32'h8000})
                begin bad++; $display("FAIL jumpreg_brc%0d got=%b/%h want=1/8000", b, PCSrc, PC_target); end
            @(negedge CLK);
        end
        EX_MEM_out = '0;
        @(negedge CLK);
    endtask

    task automatic test_word_load;
        int st; logic [31:0] a, wd; logic [3:0] be; logic we; logic [102:0] wd_done;
        mem_op(mk(2'b11, 5'b00001, 32'h1008, 32'h0, 32'h0, 1'b0, 32'h1004, 32'h0, 5'd7),
            mwb(2'b11, 32'h1008, 32'hDEADBEEF, 32'h1004, 5'd7), 3, 32'hDEADBEEF, st, a, be, wd, we, wd_done);
        total++;
        if ({a, be, we} !== {32'h1004, 4'hF, 1'b0})
            begin bad++; $display("FAIL wload_bus got=%h/%h/%b want=1004/f/0", a, be, we); end
        total++;
        if (st != 4) begin bad++; $display("FAIL wload_stall_cycles got=%0d want=4", st); end
        total++;
        if (wd_done !== '0) begin bad++; $display("FAIL wload_early got=%h want=0", wd_done); end
        total++;
        if (MEM_WB_out[68:37] !== 32'hDEADBEEF)
            begin bad++; $display("FAIL wload_data got=%h want=deadbeef", MEM_WB_out[68:37]); end
        total++;
        if (dmem.req !== 1'b0) begin bad++; $display("FAIL wload_req_clear got=%b want=0", dmem.req); end
    endtask

    task automatic test_byte_store;
        int st; logic [31:0] a, wd; logic [3:0] be; logic we; logic [102:0] wd_done;
        mem_op(mk(2'b00, 5'b10010, 32'h304, 32'h0, 32'h0, 1'b0, 32'h2003, 32'h123456A5, 5'd0),
            mwb(2'b00, 32'h304, 32'h0, 32'h2003, 5'd0), 2, 32'hFFFFFFFF, st, a, be, wd, we, wd_done);
        total++;
        if ({a, be, wd, we} !== {32'h2000, 4'b1000, 32'hA5A5A5A5, 1'b1})
            begin bad++; $display("FAIL bstore_bus got=%h/%b/%h/%b want=2000/1000/a5a5a5a5/1", a, be, wd, we); end
        total++;
        if (MEM_WB_out[68:37] !== 32'h0)
            begin bad++; $display("FAIL bstore_memdata got=%h want=0", MEM_WB_out[68:37]); end
    endtask

    task automatic test_byte_load;
        int st; logic [31:0] a, wd; logic [3:0] be; logic we; logic [102:0] wd_done;
        mem_op(mk(2'b01, 5'b10001, 32'h308, 32'h0, 32'h0, 1'b0, 32'h2002, 32'h0, 5'd9),
            mwb(2'b01, 32'h308, 32'hC3, 32'h2002, 5'd9), 1, 32'h11C32233, st, a, be, wd, we, wd_done);
        total++;
        if ({a, be} !== {32'h2000, 4'b0100})
            begin bad++; $display("FAIL bload_bus got=%h/%b want=2000/0100", a, be); end
        total++;
        if (MEM_WB_out[68:37] !== 32'h000000C3)
            begin bad++; $display("FAIL bload_data got=%h want=000000c3", MEM_WB_out[68:37]); end
    endtask

    task automatic test_reset_mid_access;
        logic [102:0] e;
        EX_MEM_out = mk(2'b11, 5'b00001, 32'h500, 32'h0, 32'h0, 1'b0, 32'h3000, 32'h0, 5'd4);
        @(negedge CLK);
        total++;
        if (dmem.req !== 1'b1) begin bad++; $display("FAIL rma_req_before got=%b want=1", dmem.req); end
        RSTN = 1'b0;
        EX_MEM_out = '0;
        @(negedge CLK);
        RSTN = 1'b1;
        #1;
        total++;
        if ({dmem.req, MEM_WB_out, Mem_stall} !== '0)
            begin bad++; $display("FAIL rma_after_reset got=%b/%h/%b want=0/0/0", dmem.req, MEM_WB_out, Mem_stall); end
        repeat (2) @(negedge CLK);
        dmem.ack = 1'b1;
        dmem.rdata = 32'hAAAA5555;
        @(negedge CLK);
        dmem.ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            total++;
            if ({dmem.req, MEM_WB_out} !== '0)
                begin bad++; $display("FAIL rma_late_ack%0d got=%b/%h want=0/0", i, dmem.req, MEM_WB_out); end
            @(negedge CLK);
        end
        e = mwb(2'b10, 32'h600, 32'h0, 32'h66, 5'd6);
        EX_MEM_out = mk(2'b10, 5'b0, 32'h600, 32'h0, 32'h0, 1'b0, 32'h66, 32'h0, 5'd6);
        exp_q.push_back(e);
        @(negedge CLK);
        total++;
        if (MEM_WB_out !== e) begin bad++; $display("FAIL rma_idle_latency got=%h want=%h", MEM_WB_out, e); end
        EX_MEM_out = '0;
        @(negedge CLK);
    endtask

    task automatic test_spurious_back_to_back;
        int st1, st2, t1, t2; logic [31:0] a, wd; logic [3:0] be; logic we; logic [102:0] wd_done, e1, e2;
        dmem.ack = 1'b1;
        dmem.rdata = 32'hFFFFFFFF;
        #1;
        total++;
        if ({dmem.req, Mem_stall} !== 2'b00) begin bad++; $display("FAIL spur_idle got=%b/%b want=0/0", dmem.req, Mem_stall); end
        @(negedge CLK);
        dmem.ack = 1'b0;
        total++;
        if ({dmem.req, MEM_WB_out} !== '0) begin bad++; $display("FAIL spur_effect got=%b/%h want=0/0", dmem.req, MEM_WB_out); end
        e1 = mwb(2'b11, 32'h44, 32'h01020304, 32'h40, 5'd1);
        e2 = mwb(2'b11, 32'h48, 32'h0A0B0C0D, 32'h44, 5'd2);
        mem_op(mk(2'b11, 5'b00001, 32'h44, 32'h0, 32'h0, 1'b0, 32'h40, 32'h0, 5'd1), e1, 1,
            32'h01020304, st1, a, be, wd, we, wd_done);
        t1 = cyc;
        total++;
        if (MEM_WB_out !== e1) begin bad++; $display("FAIL b2b_first got=%h want=%h", MEM_WB_out, e1); end
        mem_op(mk(2'b11, 5'b00001, 32'h48, 32'h0, 32'h0, 1'b0, 32'h44, 32'h0, 5'd2), e2, 1,
            32'h0A0B0C0D, st2, a, be, wd, we, wd_done);
        t2 = cyc;
        total++;
        if (MEM_WB_out !== e2) begin bad++; $display("FAIL b2b_second got=%h want=%h", MEM_WB_out, e2); end
        total++;
        if (t2 - t1 != 3) begin bad++; $display("FAIL b2b_spacing got=%0d want=3", t2 - t1); end
        total++;
        if (wd_done !== '0) begin bad++; $display("FAIL b2b_bubble got=%h want=0", wd_done); end
        total++;
        if (st1 != 2 || st2 != 2) begin bad++; $display("FAIL b2b_stalls got=%0d/%0d want=2/2", st1, st2); end
    endtask

    initial begin
        dmem.ack = 1'b0;
        dmem.rdata = '0;
        test_reset;
        test_alu;
        test_branch;
        test_jumpreg;
        test_word_load;
        test_byte_store;
        test_byte_load;
        test_reset_mid_access;
        test_spurious_back_to_back;
        repeat (3) @(negedge CLK);
        total++;
        if (exp_q.size() != 0) begin bad++; $display("FAIL scoreboard_drain got=%0d want=0", exp_q.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Pipeline MEM stage that sits directly downstream of the EX/MEM pipeline register and consumes its 173-bit bundle. It resolves branch/jump redirects and runs a req/ack handshake to a variable-latency data memory for loads and stores. While an access is outstanding it stalls the upstream pipeline. It also owns the MEM/WB pipeline register that feeds writeback.

## Interface
Parameters
- ADDR_LSB, 2, byte-offset bits of a word address; fixed for 32-bit words.

Ports
- CLK  in  1  clock; everything is rising-edge.
- RSTN  in  1  synchronous, active-low reset.
- EX_MEM_out  in  173  bundle from the EX/MEM register:
  - [172:171] WB_control
  - [170:166] MEM_control
  - [165:134] PC_plus_4
  - [133:102] Read_data1
  - [101:70] branch target
  - [69] Brc
  - [68:37] ALUresult
  - [36:5] Read_data2
  - [4:0] rd
- dmem_req  out  1  memory request; registered.
- dmem_we  out  1  1 = store, 0 = load; registered.
- dmem_addr  out  32  word-aligned address, {ALUresult[31:2],2'b00}; registered.
- dmem_wdata  out  32  store data; registered.
- dmem_be  out  4  byte enables; registered.
- dmem_ack  in  1  one-cycle completion pulse from memory.
- dmem_rdata  in  32  load data; valid in the cycle dmem_ack is high.
- Mem_stall  out  1  combinational; freezes the PC and all upstream pipeline registers.
- PCSrc  out  1  combinational; take the redirect.
- PC_target  out  32  combinational redirect address.
- MEM_WB_out  out  103  MEM/WB bundle:
  - [102:101] WB_control
  - [100:69] PC_plus_4
  - [68:37] mem_data
  - [36:5] ALUresult
  - [4:0] rd

## Operation
- MEM_control bits:
  - [0] MemRead
  - [1] MemWrite
  - [2] Branch
  - [3] JumpReg
  - [4] Byte
- mem_op = MemRead | MemWrite. If both bits are set, the access is treated as a store.
- Redirect:
  - PCSrc = (Branch & Brc) | JumpReg.
  - PC_target = JumpReg ? Read_data1 : branch target.
  - PCSrc is independent of the FSM state.
- Byte enables and store data:
  - Word access: dmem_be = 4'hF; dmem_wdata = Read_data2.
  - Byte access: dmem_be = 4'b0001 << ALUresult[1:0]; dmem_wdata = Read_data2[7:0] replicated into all four lanes.
- Load data:
  - Word load: mem_data = dmem_rdata.
  - Byte load: mem_data = the lane selected by ALUresult[1:0], zero-extended.
  - The selected data is captured into an internal 32-bit hold register on dmem_ack.
- FSM states: IDLE, ACCESS, DONE.
  - IDLE: if mem_op, go to ACCESS and load dmem_req=1, dmem_we, dmem_addr, dmem_wdata, dmem_be. Otherwise stay in IDLE.
  - ACCESS: hold all dmem_* outputs stable. On dmem_ack, capture the load data, clear dmem_req, and go to DONE.
  - DONE: go to IDLE unconditionally.
- Mem_stall = (IDLE & mem_op) | ACCESS. It is 0 in DONE.
- MEM/WB register update, every edge:
  - If Mem_stall = 1: load a bubble (all 103 bits = 0).
  - Otherwise: load {WB_control, PC_plus_4, mem_data, ALUresult, rd}. mem_data is the hold register for loads and 0 otherwise.
- dmem_ack outside ACCESS is ignored.

## Timing
- Reset (RSTN=0 at an edge):
  - State goes to IDLE.
  - dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be, MEM_WB_out and the hold register all go to 0.
  - Reset asserted mid-ACCESS abandons the access. A late dmem_ack after that is ignored.
- Non-memory instruction presented at cycle N: appears on MEM_WB_out at N+1, with no stall.
- Memory op presented at cycle N:
  - dmem_req goes high at N+1.
  - If dmem_ack arrives at cycle N+k (k≥1), DONE is in cycle N+k+1.
  - The result appears on MEM_WB_out at N+k+2.
  - Mem_stall is high for cycles N..N+k.
  - Minimum total occupancy is 3 cycles, when k=1.
- Ack held low indefinitely keeps the block in ACCESS and Mem_stall high indefinitely. There is no timeout.
- Back-to-back memory ops: the second op is seen in IDLE in the cycle after DONE, so there is no overlap.

## Structure
- Shared package cpu_pkg holds:
  - EX/MEM and MEM/WB field offsets and widths (173, 103).
  - MEM_control bit indices.
  - A mem_state_t enum {IDLE, ACCESS, DONE}.
- One sub-module: mem_wb_reg, a 103-bit register with synchronous active-low reset and a bubble input.
- Load lane selection and byte-enable generation are combinational logic inside mem_access_stage.

## Test plan
- Reset mid-access: enter ACCESS, pull RSTN low for one edge.
  - Required: dmem_req=0, MEM_WB_out=0, state IDLE.
  - Required: an ack pulse two cycles later produces no MEM/WB update.
- Word load with ALUresult=0x0000_1004, ack after 3 cycles, rdata=0xDEAD_BEEF.
  - Required: dmem_addr=0x1004, be=4'hF.
  - Required: Mem_stall high for 4 cycles.
  - Required: MEM_WB_out mem_data=0xDEAD_BEEF at cycle N+5.
- Byte store with ALUresult=0x2003, Read_data2=0x1234_56A5.
  - Required: be=4'b1000, wdata=0xA5A5_A5A5, dmem_we=1.
  - Required: MEM_WB_out mem_data=0.
- Byte load with ALUresult=0x2002, rdata=0x11C3_2233.
  - Required: mem_data=0x0000_00C3.
- Taken branch (Branch=1, Brc=1, target=0x400).
  - Required: PCSrc=1, PC_target=0x400, Mem_stall=0.
- JumpReg with Read_data1=0x8000.
  - Required: PC_target=0x8000, independent of Brc.
- Spurious ack in IDLE, and two back-to-back loads each with k=1.
  - Required: the spurious ack has no effect.
  - Required: the two loads retire 3 cycles apart, with a bubble in between.
